frame_crop_stream: RTL and testbench
====================================

# frame_crop_stream

Parametrised successor to the fixed Mono8 sequentializer/crop pair in the RHEED inference path. It accepts wide camera beats carrying `PPB = BUS_W/PIX_W` pixels of configurable width, tracks frame position, and discards whole out-of-window beats at full rate. It serialises only the in-window pixels, one per cycle, with start-of-frame (`tuser`) and end-of-frame (`tlast`) framing. It sits between the CoaxLink pixel stream and the normalisation/CNN input, under a per-frame `ap_start`/`ap_done` handshake.

## Interface
- `IN_ROWS`, 1024, input frame height.
- `IN_COLS`, 1024, input frame width; must be a multiple of PPB.
- `OUT_ROWS`, 48, crop height.
- `OUT_COLS`, 48, crop width.
- `PIX_W`, 8, bits per pixel (8, 10, 12 or 16).
- `BUS_W`, 256, input beat width; must be a multiple of PIX_W.

- `clk`  in  1  sole clock.
- `ap_rst_n`  in  1  asynchronous, active-low reset.
- `ap_start`  in  1  frame start request; sampled in IDLE only.
- `ap_ready`  out  1  high in IDLE.
- `ap_idle`  out  1  high in IDLE.
- `ap_done`  out  1  one-cycle pulse at frame end.
- `crop_x0`  in  $clog2(IN_COLS)  crop left column; latched on accepted `ap_start`.
- `crop_y0`  in  $clog2(IN_ROWS)  crop top row; latched on accepted `ap_start`.
- `cfg_err`  out  1  latched crop window is out of range; held until the next accepted `ap_start`.
- `s_axis_tvalid`, `s_axis_tready`  in/out  1  input handshake.
- `s_axis_tdata`  in  BUS_W  input beat; lane k = bits [k*PIX_W +: PIX_W], where lane 0 is the leftmost pixel.
- `m_axis_tvalid`, `m_axis_tready`  out/in  1  output handshake.
- `m_axis_tdata`  out  PIX_W  cropped pixel.
- `m_axis_tuser`  out  1  first crop pixel of the frame.
- `m_axis_tlast`  out  1  last crop pixel of the frame.

## Operation
- **FSM states:** IDLE, RUN, DONE.
- **IDLE:**
  - `ap_idle = ap_ready = 1`; `s_axis_tready = 0`.
  - On `ap_start`: latch `crop_x0`/`crop_y0`, clear row/col/output counters, and go to RUN.
  - Set `cfg_err = 1` if `crop_x0 + OUT_COLS > IN_COLS` or `crop_y0 + OUT_ROWS > IN_ROWS`; otherwise clear it.
- **RUN, beat window test:**
  - The beat covers columns `col .. col+PPB-1` in row `row`.
  - It is in-window if `row` is in [y0, y0+OUT_ROWS-1] and the column span intersects [x0, x0+OUT_COLS-1], and `cfg_err = 0`.
- **RUN, beat handling:**
  - An out-of-window beat is accepted and discarded; `s_axis_tready = 1` whenever the beat buffer is empty.
  - An in-window beat is loaded into the beat buffer, along with its first and last in-window lane indices.
  - The emitter outputs lanes first..last, one per output handshake, with no bubbles.
  - The buffer counts as empty in the same cycle its last pixel is handshaked, so `s_axis_tready` may be 1 in that cycle.
- **Counters:**
  - `col` advances by PPB per accepted beat and wraps to 0 at IN_COLS, incrementing `row`.
  - The output pixel counter has width $clog2(OUT_ROWS*OUT_COLS+1).
  - `tuser = 1` when the output count is 0; `tlast = 1` when the output count is OUT_ROWS*OUT_COLS-1.
- **Frame end:** after the last beat (`row = IN_ROWS-1`, last column) is accepted and the buffer is empty, go to DONE.
  - Remaining input is always consumed after `tlast`, to keep the camera stream aligned.
- **DONE:** `ap_done = 1` for one cycle, then IDLE.
- **cfg_err frame:** the whole frame is consumed, no output is produced, and `ap_done` still pulses.
- **Ignored inputs:** `ap_start` outside IDLE; changes to `crop_*` outside IDLE.
- **Output stability:** `m_axis_tdata`, `tuser` and `tlast` stay stable while `tvalid = 1` and `tready = 0`.

## Timing
- **Reset values:** all outputs 0 except `ap_idle = ap_ready = 1`; FSM in IDLE; counters and buffer cleared.
- **Reset mid-frame:** the pending beat and pixels are dropped and the module returns to IDLE. No `ap_done` is issued.
- **Start:** `ap_start` in IDLE at cycle t gives RUN, `s_axis_tready = 1`, at t+1.
- **Latency:** an in-window beat accepted at cycle t gives `m_axis_tvalid = 1` with the first in-window lane at t+1.
- **Throughput:** 1 pixel/cycle within the crop, 1 beat/cycle outside it. There is no extra bubble between consecutive in-window beats when `m_axis_tready = 1`.
- **Frame end:** the last input beat accepted and the final pixel handshaked at cycle t gives `ap_done` at t+1 and IDLE at t+2.

## Test plan
Common setup: `IN_ROWS=8`, `IN_COLS=16`, `PIX_W=8`, `BUS_W=32` (PPB=4), `OUT_ROWS=3`, `OUT_COLS=5`. Pixel value = row*16+col; each frame is 32 beats.

- **Basic crop:** `crop (3,2)`, `tready` held 1 -> 15 pixels in order: 0x23..0x27, 0x33..0x37, 0x43..0x47; `tuser` on 0x23, `tlast` on 0x47, then one `ap_done` pulse after beat 32.
- **Backpressure:** same crop, random `m_axis_tready` and random `s_axis_tvalid` gaps -> identical 15-pixel sequence, no loss or duplication, data stable while stalled.
- **Bad config:** `crop (12,0)` -> `cfg_err = 1`, all 32 beats accepted, zero output beats, `ap_done` pulses, `cfg_err` cleared by the next valid `ap_start`.
- **Reset mid-frame:** `ap_rst_n` low after beat 10 -> all outputs at reset values and IDLE. The next frame with crop (0,0) yields first pixel 0x00 with `tuser` and last pixel 0x24 with `tlast`.
- **Back-to-back frames:** crop (3,2) then (11,5); `ap_start` pulsed during RUN is ignored -> the second frame's first pixel is 0x5B and its last is 0x7F; exactly two `ap_done` pulses.
- **Parameter sweep:** `PIX_W=16`, `BUS_W=64` (PPB=4), crop (3,2) -> same 15 pixel values, zero-extended to 16 bits.

Source files
------------

// File: rtl/frame_crop_stream.sv
// Crops a rectangular window out of a wide-beat pixel stream: out-of-window beats
// are swallowed at full rate, in-window pixels are serialised one per cycle.
module frame_crop_stream #(
    parameter int IN_ROWS  = 1024,
    parameter int IN_COLS  = 1024,
    parameter int OUT_ROWS = 48,
    parameter int OUT_COLS = 48,
    parameter int PIX_W    = 8,
    parameter int BUS_W    = 256
) (
    input  logic                       clk,
    input  logic                       ap_rst_n,
    input  logic                       ap_start,
    output logic                       ap_ready,
    output logic                       ap_idle,
    output logic                       ap_done,
    input  logic [$clog2(IN_COLS)-1:0] crop_x0,
    input  logic [$clog2(IN_ROWS)-1:0] crop_y0,
    output logic                       cfg_err,
    input  logic                       s_axis_tvalid,
    output logic                       s_axis_tready,
    input  logic [BUS_W-1:0]           s_axis_tdata,
    output logic                       m_axis_tvalid,
    input  logic                       m_axis_tready,
    output logic [PIX_W-1:0]           m_axis_tdata,
    output logic                       m_axis_tuser,
    output logic                       m_axis_tlast
);
    localparam int PPB  = BUS_W / PIX_W;
    localparam int XW   = $clog2(IN_COLS);
    localparam int YW   = $clog2(IN_ROWS);
    localparam int LW   = (PPB > 1) ? $clog2(PPB) : 1;
    localparam int NPIX = OUT_ROWS * OUT_COLS;
    localparam int OCW  = $clog2(NPIX + 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

    state_e           state_q, state_d;
    logic [XW-1:0]    x0_q, x0_d, col_q, col_d;
    logic [YW-1:0]    y0_q, y0_d, row_q, row_d;
    logic             cfg_err_q, cfg_err_d;
    logic             beats_done_q, beats_done_d;
    logic             buf_valid_q, buf_valid_d;
    logic [BUS_W-1:0] buf_q, buf_d;
    logic [LW-1:0]    lane_q, lane_d, last_lane_q, last_lane_d;
    logic [OCW-1:0]   out_cnt_q, out_cnt_d;

    logic          win_hit;
    logic [LW-1:0] win_first, win_last;
    logic          last_beat, in_fire, out_fire, out_fire_last, buf_free;

    // Does the offered beat (row_q, col_q .. col_q+PPB-1) touch the crop window?
    always_comb begin
        int c, r, x, y, hi;
        c  = int'(col_q);
        r  = int'(row_q);
        x  = int'(x0_q);
        y  = int'(y0_q);
        hi = x + OUT_COLS - 1;
        win_hit   = !cfg_err_q && (r >= y) && (r < y + OUT_ROWS)
                    && (c <= hi) && (c + PPB - 1 >= x);
        win_first = (x > c) ? LW'(x - c) : '0;
        win_last  = (hi - c < PPB - 1) ? LW'(hi - c) : LW'(PPB - 1);
    end

    assign last_beat     = (row_q == YW'(IN_ROWS - 1)) && (col_q == XW'(IN_COLS - PPB));
    assign out_fire      = buf_valid_q && m_axis_tready;
    assign out_fire_last = out_fire && (lane_q == last_lane_q);
    // The buffer may refill in the same cycle its final pixel leaves.
    assign buf_free      = !buf_valid_q || out_fire_last;
    assign s_axis_tready = (state_q == S_RUN) && buf_free && !beats_done_q;
    assign in_fire       = s_axis_tvalid && s_axis_tready;

    // NOTE: every _d starts as its _q so no branch can leave a signal unassigned
    // and infer a latch.
    always_comb begin
        state_d      = state_q;
        x0_d         = x0_q;
        y0_d         = y0_q;
        cfg_err_d    = cfg_err_q;
        row_d        = row_q;
        col_d        = col_q;
        beats_done_d = beats_done_q;
        buf_valid_d  = buf_valid_q;
        buf_d        = buf_q;
        lane_d       = lane_q;
        last_lane_d  = last_lane_q;
        out_cnt_d    = out_cnt_q;

        case (state_q)
            S_IDLE: begin
                if (ap_start) begin
                    x0_d         = crop_x0;
                    y0_d         = crop_y0;
                    cfg_err_d    = (int'(crop_x0) + OUT_COLS > IN_COLS)
                                   || (int'(crop_y0) + OUT_ROWS > IN_ROWS);
                    row_d        = '0;
                    col_d        = '0;
                    out_cnt_d    = '0;
                    beats_done_d = 1'b0;
                    buf_valid_d  = 1'b0;
                    state_d      = S_RUN;
                end
            end
            S_RUN: begin
                if (out_fire) begin
                    out_cnt_d = out_cnt_q + 1'b1;
                    lane_d    = lane_q + 1'b1;
                    if (out_fire_last) buf_valid_d = 1'b0;
                end
                if (in_fire) begin
                    if (col_q == XW'(IN_COLS - PPB)) begin
                        col_d = '0;
                        row_d = last_beat ? '0 : row_q + 1'b1;
                    end else begin
                        col_d = col_q + XW'(PPB);
                    end
                    if (last_beat) beats_done_d = 1'b1;
                    if (win_hit) begin
                        buf_d       = s_axis_tdata;
                        buf_valid_d = 1'b1;
                        lane_d      = win_first;
                        last_lane_d = win_last;
                    end
                end
                if (beats_done_d && !buf_valid_d) state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: the beat buffer is reset along with the control state so a frame
    // aborted by reset can never present stale pixel data.
    always_ff @(posedge clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q      <= S_IDLE;
            x0_q         <= '0;
            y0_q         <= '0;
            cfg_err_q    <= 1'b0;
            row_q        <= '0;
            col_q        <= '0;
            beats_done_q <= 1'b0;
            buf_valid_q  <= 1'b0;
            buf_q        <= '0;
            lane_q       <= '0;
            last_lane_q  <= '0;
            out_cnt_q    <= '0;
        end else begin
            // NOTE: non-blocking so every flop samples values from before the edge.
            state_q      <= state_d;
            x0_q         <= x0_d;
            y0_q         <= y0_d;
            cfg_err_q    <= cfg_err_d;
            row_q        <= row_d;
            col_q        <= col_d;
            beats_done_q <= beats_done_d;
            buf_valid_q  <= buf_valid_d;
            buf_q        <= buf_d;
            lane_q       <= lane_d;
            last_lane_q  <= last_lane_d;
            out_cnt_q    <= out_cnt_d;
        end
    end

    assign ap_idle       = (state_q == S_IDLE);
    assign ap_ready      = (state_q == S_IDLE);
    assign ap_done       = (state_q == S_DONE);
    assign cfg_err       = cfg_err_q;
    assign m_axis_tvalid = buf_valid_q;
    assign m_axis_tdata  = buf_q[int'(lane_q) * PIX_W +: PIX_W];
    assign m_axis_tuser  = buf_valid_q && (out_cnt_q == '0);
    assign m_axis_tlast  = buf_valid_q && (out_cnt_q == OCW'(NPIX - 1));

endmodule

// File: tb/tb_frame_crop_stream.sv
// Bench for frame_crop_stream: an 8-bit and a 16-bit instance run the same frames
// in lockstep and are checked against a window-list model of the crop.
module tb_frame_crop_stream;
    localparam int IR = 8, IC = 16, OR = 3, OC = 5;

    typedef struct packed {
        logic [7:0] v;
        logic       u;
        logic       l;
    } px_t;

    logic        clk = 1'b0, ap_rst_n = 1'b0, ap_start = 1'b0;
    logic [3:0]  crop_x0 = '0;
    logic [2:0]  crop_y0 = '0;
    logic        s_tvalid = 1'b0, m_tready = 1'b0, rand_rdy = 1'b0;
    logic [31:0] s_tdata = '0;
    logic [63:0] s_tdata_w;

    logic        ap_ready, ap_idle, ap_done, cfg_err, s_tready, m_tvalid, m_tuser, m_tlast;
    logic [7:0]  m_tdata;
    logic        ap_ready_w, ap_idle_w, ap_done_w, cfg_err_w, s_tready_w, m_tvalid_w, m_tuser_w, m_tlast_w;
    logic [15:0] m_tdata_w;

    assign s_tdata_w = {8'h00, s_tdata[31:24], 8'h00, s_tdata[23:16],
                        8'h00, s_tdata[15:8],  8'h00, s_tdata[7:0]};

    frame_crop_stream #(.IN_ROWS(IR), .IN_COLS(IC), .OUT_ROWS(OR), .OUT_COLS(OC),
                        .PIX_W(8), .BUS_W(32)) dut (
        .clk(clk), .ap_rst_n(ap_rst_n), .ap_start(ap_start), .ap_ready(ap_ready),
        .ap_idle(ap_idle), .ap_done(ap_done), .crop_x0(crop_x0), .crop_y0(crop_y0),
        .cfg_err(cfg_err), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
        .s_axis_tdata(s_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
        .m_axis_tdata(m_tdata), .m_axis_tuser(m_tuser), .m_axis_tlast(m_tlast));

    frame_crop_stream #(.IN_ROWS(IR), .IN_COLS(IC), .OUT_ROWS(OR), .OUT_COLS(OC),
                        .PIX_W(16), .BUS_W(64)) dut_w (
        .clk(clk), .ap_rst_n(ap_rst_n), .ap_start(ap_start), .ap_ready(ap_ready_w),
        .ap_idle(ap_idle_w), .ap_done(ap_done_w), .crop_x0(crop_x0), .crop_y0(crop_y0),
        .cfg_err(cfg_err_w), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready_w),
        .s_axis_tdata(s_tdata_w), .m_axis_tvalid(m_tvalid_w), .m_axis_tready(m_tready),
        .m_axis_tdata(m_tdata_w), .m_axis_tuser(m_tuser_w), .m_axis_tlast(m_tlast_w));

    always #5 clk = ~clk;

    int n_cmp = 0, n_bad = 0;
    int cyc = 0, start_cyc = 0, done_cnt = 0, done_cyc = 0, px_cnt = 0;
    logic [7:0] first_px, last_px;
    px_t exp_q[$], exp_w_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial forever begin
        @(posedge clk);
        #1;
        m_tready = rand_rdy ? ($urandom_range(0, 1) == 1) : 1'b1;
    end

    // Compare process: every output handshake pops the model; stalled outputs must hold.
    initial begin
        logic        hold_p = 1'b0, hold_w_p = 1'b0;
        logic [9:0]  hold_v;
        logic [17:0] hold_w_v;
        px_t e;
        forever begin
            @(negedge clk);
            if (!ap_rst_n) begin
                hold_p   = 1'b0;
                hold_w_p = 1'b0;
            end else begin
                if (ap_done) begin
                    done_cnt++;
                    done_cyc = cyc;
                end
                if (hold_p)
                    check("hold8", {m_tvalid, m_tdata, m_tuser, m_tlast}, {1'b1, hold_v});
                if (hold_w_p)
                    check("hold16", {m_tvalid_w, m_tdata_w, m_tuser_w, m_tlast_w}, {1'b1, hold_w_v});
                hold_p   = m_tvalid && !m_tready;
                hold_v   = {m_tdata, m_tuser, m_tlast};
                hold_w_p = m_tvalid_w && !m_tready;
                hold_w_v = {m_tdata_w, m_tuser_w, m_tlast_w};
                if (m_tvalid && m_tready) begin
                    check("pix8_expected", exp_q.size() > 0, 1);
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        check("pix8", {m_tdata, m_tuser, m_tlast}, {e.v, e.u, e.l});
                    end
                    px_cnt++;
                    if (m_tuser) first_px = m_tdata;
                    if (m_tlast) last_px = m_tdata;
                end
                if (m_tvalid_w && m_tready) begin
                    check("pix16_expected", exp_w_q.size() > 0, 1);
                    if (exp_w_q.size() > 0) begin
                        e = exp_w_q.pop_front();
                        check("pix16", {m_tdata_w, m_tuser_w, m_tlast_w}, {8'h00, e.v, e.u, e.l});
                    end
                end
            end
        end
    end

    // Model: the crop is simply the listed window pixels in raster order.
    task automatic push_model(input int x0, input int y0);
        px_t e;
        if (x0 + OC > IC || y0 + OR > IR) return;
        for (int r = 0; r < OR; r++) begin
            for (int c = 0; c < OC; c++) begin
                e.v = 8'((y0 + r) * 16 + x0 + c);
                e.u = (r == 0 && c == 0);
                e.l = (r == OR - 1 && c == OC - 1);
                exp_q.push_back(e);
                exp_w_q.push_back(e);
            end
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_ctl8"}, {ap_idle, ap_ready, ap_done, cfg_err, s_tready}, 5'b11000);
        check({tag, "_out8"}, {m_tvalid, m_tuser, m_tlast, m_tdata}, 11'h0);
        check({tag, "_ctl16"}, {ap_idle_w, ap_ready_w, ap_done_w, cfg_err_w, s_tready_w}, 5'b11000);
        check({tag, "_out16"}, {m_tvalid_w, m_tuser_w, m_tlast_w, m_tdata_w}, 19'h0);
    endtask

    task automatic start_frame(input int x0, input int y0);
        logic bad;
        bad      = (x0 + OC > IC) || (y0 + OR > IR);
        crop_x0  = 4'(x0);
        crop_y0  = 3'(y0);
        push_model(x0, y0);
        px_cnt   = 0;
        first_px = 8'hEE;
        last_px  = 8'hEE;
        ap_start = 1'b1;
        @(posedge clk);
        #1;
        ap_start  = 1'b0;
        start_cyc = cyc;
        crop_x0   = ~crop_x0;
        crop_y0   = ~crop_y0;
        check("start_ready", {s_tready, s_tready_w, ap_idle, ap_idle_w}, 4'b1100);
        check("cfg_err", {cfg_err, cfg_err_w}, {bad, bad});
    endtask

    task automatic feed(input int first, input int last, input bit gaps);
        for (int b = first; b <= last; b++) begin
            int budget;
            bit acc;
            if (gaps && $urandom_range(0, 2) == 0) begin
                s_tvalid = 1'b0;
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
            for (int k = 0; k < 4; k++) s_tdata[k*8 +: 8] = 8'((b / 4) * 16 + (b % 4) * 4 + k);
            s_tvalid = 1'b1;
            budget   = 0;
            acc      = 1'b0;
            while (!acc && budget < 100) begin
                @(negedge clk);
                acc = s_tready;
                @(posedge clk);
                #1;
                budget++;
            end
            check("beat_accepted", acc, 1);
        end
        s_tvalid = 1'b0;
    endtask

    task automatic wait_done(input int exp_cycles);
        int d0, budget;
        d0     = done_cnt;
        budget = 0;
        while (done_cnt == d0 && budget < 400) begin
            @(posedge clk);
            #1;
            budget++;
        end
        check("done_seen", done_cnt - d0, 1);
        if (exp_cycles >= 0) check("frame_cycles", done_cyc - start_cyc, exp_cycles);
        @(negedge clk);
        #1;
        check("idle_after_done", {ap_idle, ap_idle_w, ap_done}, 3'b110);
        check("done_single_pulse", done_cnt - d0, 1);
        check("model_drained", exp_q.size() + exp_w_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int d0;
        repeat (3) @(posedge clk);
        #1;
        check_reset("por");
        ap_rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic crop, full rate.
        start_frame(3, 2);
        feed(0, 31, 0);
        wait_done(41);
        check("basic_first", first_px, 8'h23);
        check("basic_last", last_px, 8'h47);
        check("basic_count", px_cnt, 15);

        // Backpressure on both sides.
        rand_rdy = 1'b1;
        start_frame(3, 2);
        feed(0, 31, 1);
        wait_done(-1);
        rand_rdy = 1'b0;
        check("bp_first", first_px, 8'h23);
        check("bp_last", last_px, 8'h47);
        check("bp_count", px_cnt, 15);

        // Out-of-range window: frame consumed, nothing emitted.
        start_frame(12, 0);
        feed(0, 31, 0);
        wait_done(32);
        check("bad_count", px_cnt, 0);

        // Reset in the middle of a frame.
        start_frame(3, 2);
        feed(0, 9, 0);
        d0       = done_cnt;
        ap_rst_n = 1'b0;
        exp_q.delete();
        exp_w_q.delete();
        #1;
        check_reset("mid_reset");
        repeat (2) @(posedge clk);
        #1;
        ap_rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("no_done_on_reset", done_cnt - d0, 0);
        check_reset("after_reset");
        start_frame(0, 0);
        feed(0, 31, 0);
        wait_done(41);
        check("rst_first", first_px, 8'h00);
        check("rst_last", last_px, 8'h24);

        // Back-to-back frames with a stray ap_start during RUN.
        d0 = done_cnt;
        start_frame(3, 2);
        feed(0, 15, 0);
        ap_start = 1'b1;
        @(posedge clk);
        #1;
        ap_start = 1'b0;
        check("start_ignored", {ap_idle, ap_done}, 2'b00);
        feed(16, 31, 0);
        wait_done(-1);
        check("b2b1_first", first_px, 8'h23);
        check("b2b1_last", last_px, 8'h47);
        start_frame(11, 5);
        feed(0, 31, 0);
        wait_done(42);
        check("b2b2_first", first_px, 8'h5B);
        check("b2b2_last", last_px, 8'h7F);
        check("b2b_done_count", done_cnt - d0, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, compared %0d mismatched %0d", n_cmp, n_bad);
        $fatal(1);
    end

endmodule
